// File: rtl/sweep_sched.sv
// sweep_sched: owns the mem port, lends it to the loader, then repeats machine passes until one reports no change.
// Optional SWEEP_STATS_EN adds a saturating count of cycles spent sweeping on sweep_cycles_out.
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 8
`endif
`ifndef COL_ADDR_WIDTH
`define COL_ADDR_WIDTH 4
`endif
`ifndef TX_DATA_WIDTH
`define TX_DATA_WIDTH 32
`endif

module sweep_sched #(
  parameter int MAX_PASSES    = 255,
  parameter int PASS_CNT_W    = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        ld_write_en_in,
  input  logic                        ld_read_en_in,
  input  logic                        ld_pad_en_in,
  input  logic [`BANK_ADDR_WIDTH-1:0] ld_row_addr_in,
  input  logic [`COL_ADDR_WIDTH-1:0]  ld_col_addr_in,
  input  logic [`TX_DATA_WIDTH-1:0]   ld_partial_vec_in,
  output logic                        ld_ack_out,
  input  logic                        load_done_in,
  input  logic                        mach_write_en_in,
  input  logic                        mach_read_en_in,
  input  logic [`BANK_ADDR_WIDTH-1:0] mach_row_addr_in,
  input  logic [`COL_ADDR_WIDTH-1:0]  mach_col_addr_in,
  input  logic [`TX_DATA_WIDTH-1:0]   mach_partial_vec_in,
  input  logic                        mach_done_in,
  input  logic                        mach_changed_in,
  output logic                        mach_run_out,
  output logic                        mach_ack_out,
  output logic                        mem_write_en_out,
  output logic                        mem_read_en_out,
  output logic                        mem_pad_en_out,
  output logic [`BANK_ADDR_WIDTH-1:0] mem_row_addr_out,
  output logic [`COL_ADDR_WIDTH-1:0]  mem_col_addr_out,
  output logic [`TX_DATA_WIDTH-1:0]   mem_partial_vec_out,
  input  logic                        mem_ack_in,
  input  logic                        mem_busy_in,
  output logic                        busy_out,
  output logic                        converged_out,
  output logic                        limit_out,
  output logic [PASS_CNT_W-1:0]       pass_count_out,
  output logic [31:0]                 sweep_cycles_out
);
  typedef enum logic [2:0] {LOAD, DRAIN, RUN, WAIT, SETTLE, CHECK, FINISH, LIMIT} state_t;
  localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  state_t state_q, state_d;
  logic done_q, changed_q, changed_d, converged_q, converged_d, limit_q, limit_d;
  logic [PASS_CNT_W-1:0] pass_q, pass_d;
  logic [SW-1:0] settle_q, settle_d;
  logic ld_own, mach_en, rise;
  assign ld_own  = state_q inside {LOAD, FINISH, LIMIT};
  assign mach_en = state_q == WAIT;
  // only a fresh rising edge ends a pass; a level left high from the previous pass does not
  assign rise    = mach_done_in & ~done_q;
  assign mem_write_en_out    = ld_own ? ld_write_en_in : mach_en & mach_write_en_in;
  assign mem_read_en_out     = ld_own ? ld_read_en_in : mach_en & mach_read_en_in;
  assign mem_pad_en_out      = ld_own & ld_pad_en_in;
  assign mem_row_addr_out    = ld_own ? ld_row_addr_in : mach_row_addr_in;
  assign mem_col_addr_out    = ld_own ? ld_col_addr_in : mach_col_addr_in;
  assign mem_partial_vec_out = ld_own ? ld_partial_vec_in : mach_partial_vec_in;
  assign ld_ack_out     = ld_own & mem_ack_in;
  assign mach_ack_out   = ~ld_own & mem_ack_in;
  assign mach_run_out   = state_q == RUN;
  assign busy_out       = state_q inside {DRAIN, RUN, WAIT, SETTLE, CHECK};
  assign converged_out  = converged_q;
  assign limit_out      = limit_q;
  assign pass_count_out = pass_q;
  always_comb begin
    state_d     = state_q;
    pass_d      = pass_q;
    settle_d    = settle_q;
    changed_d   = changed_q;
    converged_d = converged_q;
    limit_d     = limit_q;
    case (state_q)
      LOAD:  if (load_done_in) state_d = DRAIN;
      DRAIN: if (!mem_busy_in && !mem_ack_in) state_d = RUN;
      RUN: begin
        state_d = WAIT;
        pass_d  = &pass_q ? pass_q : pass_q + PASS_CNT_W'(1);
      end
      WAIT: if (rise) begin
        changed_d = mach_changed_in;
        settle_d  = '0;
        state_d   = SETTLE_CYCLES == 0 ? CHECK : SETTLE;
      end
      SETTLE: begin
        state_d  = settle_q == SW'(SETTLE_CYCLES - 1) ? CHECK : SETTLE;
        settle_d = settle_q + SW'(1);
      end
      CHECK: begin
        state_d     = !changed_q ? FINISH : pass_q == PASS_CNT_W'(MAX_PASSES) ? LIMIT : RUN;
        converged_d = !changed_q;
        limit_d     = changed_q && pass_q == PASS_CNT_W'(MAX_PASSES);
      end
      default: ;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= LOAD;
      done_q      <= 1'b0;
      changed_q   <= 1'b0;
      converged_q <= 1'b0;
      limit_q     <= 1'b0;
      pass_q      <= '0;
      settle_q    <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= mach_done_in;
      changed_q   <= changed_d;
      converged_q <= converged_d;
      limit_q     <= limit_d;
      pass_q      <= pass_d;
      settle_q    <= settle_d;
    end
  end
`ifdef SWEEP_STATS_EN
  logic [31:0] cyc_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cyc_q <= '0;
    else if (busy_out && !(&cyc_q)) cyc_q <= cyc_q + 32'd1;
  end
  assign sweep_cycles_out = cyc_q;
`else
  assign sweep_cycles_out = '0;
`endif
endmodule

// File: tb/tb_sweep_sched.sv
// tb_sweep_sched: randomized sweeps against a pass-outcome model; a monitor pops expected results at each terminal state.
module tb_sweep_sched;
  localparam int MAX_P = 4;
  localparam int PW = 16;
  logic clock = 0, reset = 0;
  logic ld_write_en_in = 0, ld_read_en_in = 0, ld_pad_en_in = 0, load_done_in = 0;
  logic [7:0] ld_row_addr_in = 0, mach_row_addr_in = 0;
  logic [3:0] ld_col_addr_in = 0, mach_col_addr_in = 0;
  logic [31:0] ld_partial_vec_in = 0, mach_partial_vec_in = 0;
  logic mach_write_en_in = 0, mach_read_en_in = 0, mach_done_in = 0, mach_changed_in = 0;
  logic mem_ack_in = 0, mem_busy_in = 0;
  logic ld_ack_out, mach_run_out, mach_ack_out, mem_write_en_out, mem_read_en_out, mem_pad_en_out;
  logic [7:0] mem_row_addr_out;
  logic [3:0] mem_col_addr_out;
  logic [31:0] mem_partial_vec_out, sweep_cycles_out;
  logic busy_out, converged_out, limit_out;
  logic [PW-1:0] pass_count_out;

  sweep_sched #(.MAX_PASSES(MAX_P), .PASS_CNT_W(PW), .SETTLE_CYCLES(2)) dut (
    .clock(clock), .reset(reset),
    .ld_write_en_in(ld_write_en_in), .ld_read_en_in(ld_read_en_in), .ld_pad_en_in(ld_pad_en_in),
    .ld_row_addr_in(ld_row_addr_in), .ld_col_addr_in(ld_col_addr_in), .ld_partial_vec_in(ld_partial_vec_in),
    .ld_ack_out(ld_ack_out), .load_done_in(load_done_in),
    .mach_write_en_in(mach_write_en_in), .mach_read_en_in(mach_read_en_in),
    .mach_row_addr_in(mach_row_addr_in), .mach_col_addr_in(mach_col_addr_in),
    .mach_partial_vec_in(mach_partial_vec_in), .mach_done_in(mach_done_in), .mach_changed_in(mach_changed_in),
    .mach_run_out(mach_run_out), .mach_ack_out(mach_ack_out),
    .mem_write_en_out(mem_write_en_out), .mem_read_en_out(mem_read_en_out), .mem_pad_en_out(mem_pad_en_out),
    .mem_row_addr_out(mem_row_addr_out), .mem_col_addr_out(mem_col_addr_out),
    .mem_partial_vec_out(mem_partial_vec_out), .mem_ack_in(mem_ack_in), .mem_busy_in(mem_busy_in),
    .busy_out(busy_out), .converged_out(converged_out), .limit_out(limit_out),
    .pass_count_out(pass_count_out), .sweep_cycles_out(sweep_cycles_out)
  );

  always #5 clock = ~clock;

  typedef struct {int passes; bit conv; bit lim;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  logic [7:0] chg;
  bit seen = 0;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", n, a, e);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // outcome of a sweep: first pass reporting no change ends it, else the pass limit does
  function automatic exp_t model(input logic [7:0] c);
    exp_t e;
    e.passes = MAX_P; e.conv = 0; e.lim = 1;
    for (int i = 0; i < MAX_P; i++)
      if (!c[i]) begin
        e.passes = i + 1; e.conv = 1; e.lim = 0;
        break;
      end
    return e;
  endfunction

  always @(negedge clock) begin
    if (!reset) seen = 0;
    else if ((converged_out || limit_out) && !seen) begin
      seen = 1;
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("pass_count", pass_count_out, e.passes);
        chk("converged", converged_out, e.conv);
        chk("limit", limit_out, e.lim);
      end
    end
  end

  task automatic sweep(input bit stale, input int abort_at);
    int runs, k, g, extra;
    bit stale_pending;
    reset = 0; ld_write_en_in = 1; ld_pad_en_in = 1;
    repeat (3) tick;
    chk("rst_busy", busy_out, 0);
    chk("rst_pass", pass_count_out, 0);
    chk("rst_conv_lim", {converged_out, limit_out, mach_run_out}, 0);
    chk("rst_ld_wr", mem_write_en_out, 1);
    chk("rst_pad", mem_pad_en_out, 1);
    chk("rst_cycles", sweep_cycles_out, 0);
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      ld_write_en_in = 1; ld_row_addr_in = 8'($urandom); mem_ack_in = 0;
      #1 chk("ld_row", mem_row_addr_out, ld_row_addr_in);
      tick;
      ld_write_en_in = 0; mem_ack_in = 1;
      #1 chk("ld_ack", ld_ack_out, 1);
      chk("ld_mach_ack", mach_ack_out, 0);
      chk("ld_run", mach_run_out, 0);
      tick;
      mem_ack_in = 0;
    end
    load_done_in = 1; ld_write_en_in = 1;
    #1 chk("done_fwd_wr", mem_write_en_out, 1);
    tick;
    load_done_in = 0; ld_write_en_in = 0; mem_busy_in = 1; mach_write_en_in = 1;
    #1 chk("drain_busy", busy_out, 1);
    chk("drain_wr_forced", mem_write_en_out, 0);
    chk("drain_pad", mem_pad_en_out, 0);
    mach_write_en_in = 0;
    tick;
    mem_busy_in = 0;
    sb.push_back(model(chg));
    runs = 0; k = 0; stale_pending = 0;
    while (1) begin
      for (g = 0; g < 40 && !mach_run_out && !(converged_out || limit_out); g++) tick;
      if (converged_out || limit_out) break;
      if (!mach_run_out) begin
        chk("run_timeout", 0, 1);
        break;
      end
      runs++;
      if (stale_pending) begin
        extra = 0;
        for (int i = 0; i < 8; i++) begin
          tick;
          if (mach_run_out) extra++;
        end
        chk("stale_extra_run", extra, 0);
        chk("stale_busy", busy_out, 1);
        mach_done_in = 0; stale_pending = 0;
      end else begin
        tick;
        chk("run_pulse_width", mach_run_out, 0);
      end
      if (k == abort_at) begin
        #3 reset = 0;
        #1 chk("abort_pass", pass_count_out, 0);
        chk("abort_busy", busy_out, 0);
        chk("abort_cycles", sweep_cycles_out, 0);
        void'(sb.pop_back());
        return;
      end
      mach_read_en_in = 1; mem_ack_in = 1; mach_row_addr_in = 8'($urandom);
      #1 chk("wait_rd", mem_read_en_out, 1);
      chk("wait_ack", {mach_ack_out, ld_ack_out, mem_pad_en_out}, 3'b100);
      chk("wait_row", mem_row_addr_out, mach_row_addr_in);
      tick;
      mach_read_en_in = 0; mem_ack_in = 0;
      repeat ($urandom_range(0, 3)) tick;
      mach_changed_in = chg[k]; mach_done_in = 1;
      tick;
      if (stale && k == 0) stale_pending = 1;
      else mach_done_in = 0;
      k++;
    end
    mach_done_in = 0;
    chk("run_count", runs, model(chg).passes);
    ld_write_en_in = 1;
    #1 chk("end_ld_wr", mem_write_en_out, 1);
    chk("end_busy", busy_out, 0);
`ifdef SWEEP_STATS_EN
    chk("cycles_nz", sweep_cycles_out != 0, 1);
`else
    chk("cycles_zero", sweep_cycles_out, 0);
`endif
    ld_write_en_in = 0;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    chg = 8'b0000_0011; sweep(0, -1);
    chg = 8'b1111_1111; sweep(0, -1);
    chg = 8'b0000_0011; sweep(1, -1);
    chg = 8'b0000_0011; sweep(0, 1);
    chg = 8'b0000_0011; sweep(0, -1);
    repeat (6) begin
      for (int i = 0; i < 8; i++) chg[i] = $urandom_range(0, 2) != 0;
      sweep($urandom_range(0, 1) == 1, -1);
    end
    repeat (3) tick;
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
